// File: rtl/ccc_lock_sequencer.sv
// ccc_lock_sequencer: CCC/PLL reset, lock qualification and fabric reset release.
// Optional LOSS_CNT/LOSS_STICKY outputs when CCC_LOSS_CNT_EN is defined.
module ccc_lock_sequencer #(
  parameter int ARST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int STABLE_CYCLES = 256,
  parameter int MAX_RETRY     = 3,
  parameter int CNT_W         = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       LOCK,
  input  logic       RETRY_REQ,
  output logic       PLL_ARST_N,
  output logic       FABRIC_RESET_N,
  output logic       READY,
  output logic       FAULT,
  output logic [2:0] STATE,
  output logic [1:0] RETRY_CNT
`ifdef CCC_LOSS_CNT_EN
  ,
  output logic [7:0] LOSS_CNT,
  output logic       LOSS_STICKY
`endif
);

  // Failure counter must hold MAX_RETRY and the saturated value 3.
  localparam int FW_RAW = $clog2(MAX_RETRY + 1);
  localparam int FW     = (FW_RAW < 2) ? 2 : FW_RAW;

  localparam logic [CNT_W-1:0] ARST_LAST =
    CNT_W'(ARST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STAB_LAST =
    CNT_W'(STABLE_CYCLES - 1);
  localparam logic [FW-1:0] FAIL_MAX =
    FW'(MAX_RETRY);
  localparam logic [FW-1:0] FAIL_SAT =
    FW'(3);

  typedef enum logic [2:0] {
    S_ARST   = 3'd0,
    S_WAIT   = 3'd1,
    S_STABLE = 3'd2,
    S_RUN    = 3'd3,
    S_LOST   = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  logic [1:0]       r_sync;
  logic             w_lock_s;

  state_t           r_state;
  state_t           w_nxt_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_nxt_cnt;
  logic [FW-1:0]    r_fail;
  logic [FW-1:0]    w_nxt_fail;
  logic [FW-1:0]    w_fail_inc;

  logic             r_pll_arst_n;
  logic             r_fabric_rst_n;
  logic             r_ready;
  logic             r_fault;
  logic [1:0]       r_retry;

  logic             w_o_pll_arst_n;
  logic             w_o_fabric_rst_n;
  logic             w_o_ready;
  logic             w_o_fault;
  logic [1:0]       w_o_retry;

  assign w_lock_s = r_sync[1];

  // Two-flop synchronizer bringing LOCK into the CLK domain.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], LOCK};
    end
  end

  // State, phase counter and failed-attempt counter.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_ARST;
      r_cnt   <= '0;
      r_fail  <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      r_fail  <= w_nxt_fail;
    end
  end

  // Next-state logic; lock_s wins over an expiring timeout.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_fail  = r_fail;
    w_fail_inc  = r_fail + 1'b1;
    unique case (r_state)
      S_ARST: begin
        if (r_cnt == ARST_LAST) begin
          w_nxt_state = S_WAIT;
          w_nxt_cnt   = '0;
        end else begin
          w_nxt_cnt = r_cnt + 1'b1;
        end
      end
      S_WAIT: begin
        if (w_lock_s) begin
          w_nxt_state = S_STABLE;
          w_nxt_cnt   = '0;
        end else if (r_cnt == TMO_LAST) begin
          w_nxt_fail = w_fail_inc;
          w_nxt_cnt  = '0;
          if (w_fail_inc == FAIL_MAX) begin
            w_nxt_state = S_FAULT;
          end else begin
            w_nxt_state = S_ARST;
          end
        end else begin
          w_nxt_cnt = r_cnt + 1'b1;
        end
      end
      S_STABLE: begin
        if (!w_lock_s) begin
          w_nxt_state = S_WAIT;
          w_nxt_cnt   = '0;
        end else if (r_cnt == STAB_LAST) begin
          w_nxt_state = S_RUN;
          w_nxt_cnt   = '0;
          w_nxt_fail  = '0;
        end else begin
          w_nxt_cnt = r_cnt + 1'b1;
        end
      end
      S_RUN: begin
        if (!w_lock_s) begin
          w_nxt_state = S_LOST;
          w_nxt_cnt   = '0;
        end
      end
      S_LOST: begin
        w_nxt_state = S_ARST;
        w_nxt_cnt   = '0;
      end
      S_FAULT: begin
        if (RETRY_REQ) begin
          w_nxt_state = S_ARST;
          w_nxt_cnt   = '0;
          w_nxt_fail  = '0;
        end
      end
      default: begin
        w_nxt_state = S_ARST;
        w_nxt_cnt   = '0;
        w_nxt_fail  = '0;
      end
    endcase
  end

  // Output decode of the next state so registered outputs track r_state.
  always_comb begin
    w_o_pll_arst_n   = 1'b1;
    w_o_fabric_rst_n = 1'b0;
    w_o_ready        = 1'b0;
    w_o_fault        = 1'b0;
    unique case (w_nxt_state)
      S_ARST: begin
        w_o_pll_arst_n = 1'b0;
      end
      S_RUN: begin
        w_o_fabric_rst_n = 1'b1;
        w_o_ready        = 1'b1;
      end
      S_FAULT: begin
        w_o_pll_arst_n = 1'b0;
        w_o_fault      = 1'b1;
      end
      default: begin
        w_o_pll_arst_n = 1'b1;
      end
    endcase
    if (w_nxt_fail >= FAIL_SAT) begin
      w_o_retry = 2'd3;
    end else begin
      w_o_retry = w_nxt_fail[1:0];
    end
  end

  // Registered outputs, glitch-free toward the CCC and reset tree.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_pll_arst_n   <= 1'b0;
      r_fabric_rst_n <= 1'b0;
      r_ready        <= 1'b0;
      r_fault        <= 1'b0;
      r_retry        <= 2'd0;
    end else begin
      r_pll_arst_n   <= w_o_pll_arst_n;
      r_fabric_rst_n <= w_o_fabric_rst_n;
      r_ready        <= w_o_ready;
      r_fault        <= w_o_fault;
      r_retry        <= w_o_retry;
    end
  end

  assign PLL_ARST_N     = r_pll_arst_n;
  assign FABRIC_RESET_N = r_fabric_rst_n;
  assign READY          = r_ready;
  assign FAULT          = r_fault;
  assign STATE          = r_state;
  assign RETRY_CNT      = r_retry;

`ifdef CCC_LOSS_CNT_EN
  logic [7:0] r_loss_cnt;
  logic       r_loss_sticky;
  logic       w_loss_ev;

  assign w_loss_ev = (r_state == S_RUN) &&
                     (w_nxt_state == S_LOST);

  // Saturating count of RUN->LOST events; only RESET clears it.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_loss_cnt    <= 8'd0;
      r_loss_sticky <= 1'b0;
    end else if (w_loss_ev) begin
      if (r_loss_cnt != 8'hFF) begin
        r_loss_cnt <= r_loss_cnt + 8'd1;
      end
      r_loss_sticky <= 1'b1;
    end
  end

  assign LOSS_CNT    = r_loss_cnt;
  assign LOSS_STICKY = r_loss_sticky;
`endif

endmodule

// File: tb/tb_ccc_lock_sequencer.sv
// tb_ccc_lock_sequencer: directed and random checks of the lock sequencer
// against a phase/duration reference model.
module tb_ccc_lock_sequencer;

  localparam int ARST_C = 4;
  localparam int TMO_C  = 20;
  localparam int STAB_C = 8;
  localparam int MAXR_C = 3;

  localparam int P_ARST  = 0;
  localparam int P_WAIT  = 1;
  localparam int P_STAB  = 2;
  localparam int P_RUN   = 3;
  localparam int P_LOST  = 4;
  localparam int P_FAULT = 5;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       LOCK = 1'b0;
  logic       RETRY_REQ = 1'b0;
  logic       PLL_ARST_N;
  logic       FABRIC_RESET_N;
  logic       READY;
  logic       FAULT;
  logic [2:0] STATE;
  logic [1:0] RETRY_CNT;
`ifdef CCC_LOSS_CNT_EN
  logic [7:0] LOSS_CNT;
  logic       LOSS_STICKY;
`endif

  int errors = 0;
  int checks = 0;

  int m_ph = P_ARST;
  int m_t = 0;
  int m_fail = 0;
  int m_loss = 0;
  bit m_sticky = 1'b0;
  bit m_h1 = 1'b0;
  bit m_h2 = 1'b0;

  ccc_lock_sequencer #(
    .ARST_CYCLES  (ARST_C),
    .LOCK_TIMEOUT (TMO_C),
    .STABLE_CYCLES(STAB_C),
    .MAX_RETRY    (MAXR_C),
    .CNT_W        (16)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .LOCK          (LOCK),
    .RETRY_REQ     (RETRY_REQ),
    .PLL_ARST_N    (PLL_ARST_N),
    .FABRIC_RESET_N(FABRIC_RESET_N),
    .READY         (READY),
    .FAULT         (FAULT),
    .STATE         (STATE),
    .RETRY_CNT     (RETRY_CNT)
`ifdef CCC_LOSS_CNT_EN
    ,
    .LOSS_CNT      (LOSS_CNT),
    .LOSS_STICKY   (LOSS_STICKY)
`endif
  );

  always #5 CLK = ~CLK;

  function automatic logic [17:0] dut_vec();
    logic [8:0] lv;
`ifdef CCC_LOSS_CNT_EN
    lv = {LOSS_CNT, LOSS_STICKY};
`else
    lv = 9'd0;
`endif
    return {lv, PLL_ARST_N, FABRIC_RESET_N,
            READY, FAULT, STATE, RETRY_CNT};
  endfunction

  function automatic logic [17:0] model_vec();
    logic [8:0] lv;
    logic [1:0] rc;
    logic       pll;
    logic       run;
    logic       flt;
`ifdef CCC_LOSS_CNT_EN
    lv = {8'(m_loss), m_sticky};
`else
    lv = 9'd0;
`endif
    rc  = (m_fail > 3) ? 2'd3 : 2'(m_fail);
    pll = !(m_ph == P_ARST || m_ph == P_FAULT);
    run = (m_ph == P_RUN);
    flt = (m_ph == P_FAULT);
    return {lv, pll, run, run, flt, 3'(m_ph), rc};
  endfunction

  // Reference behaviour: phases with elapsed-time counts; lock_s is
  // LOCK delayed by two samples.
  task automatic model_update();
    bit ls;
    if (RESET) begin
      m_ph = P_ARST; m_t = 0; m_fail = 0;
      m_loss = 0; m_sticky = 0;
      m_h1 = 0; m_h2 = 0;
      return;
    end
    ls = m_h2;
    m_h2 = m_h1;
    m_h1 = LOCK;
    case (m_ph)
      P_ARST: begin
        m_t++;
        if (m_t == ARST_C) begin
          m_ph = P_WAIT; m_t = 0;
        end
      end
      P_WAIT: begin
        if (ls) begin
          m_ph = P_STAB; m_t = 0;
        end else begin
          m_t++;
          if (m_t == TMO_C) begin
            m_fail++;
            m_t = 0;
            m_ph = (m_fail == MAXR_C) ? P_FAULT : P_ARST;
          end
        end
      end
      P_STAB: begin
        if (!ls) begin
          m_ph = P_WAIT; m_t = 0;
        end else begin
          m_t++;
          if (m_t == STAB_C) begin
            m_ph = P_RUN; m_fail = 0;
          end
        end
      end
      P_RUN: begin
        if (!ls) begin
          m_ph = P_LOST;
          if (m_loss < 255) m_loss++;
          m_sticky = 1;
        end
      end
      P_LOST: begin
        m_ph = P_ARST; m_t = 0;
      end
      default: begin
        if (RETRY_REQ) begin
          m_ph = P_ARST; m_t = 0; m_fail = 0;
        end
      end
    endcase
  endtask

  task automatic step();
    @(posedge CLK);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    RETRY_REQ = 1'b0;
    step();
    step();
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    LOCK = 1'($urandom);
    repeat (3) step();
    checks++;
    if (dut_vec() !== 18'd0) begin
      errors++;
      $display("FAIL reset_vals got=%h exp=%h",
               dut_vec(), 18'd0);
    end
    checks++;
    if (dut_vec() !== model_vec()) begin
      errors++;
      $display("FAIL reset_model got=%h exp=%h",
               dut_vec(), model_vec());
    end
    LOCK = 1'b0;
  endtask

  task automatic test_nominal();
    int n_low;
    int rdy;
    LOCK = 1'b0;
    do_reset();
    n_low = 0;
    rdy = -1;
    for (int k = 0; k <= 24; k++) begin
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        $display("FAIL nominal_model k=%0d got=%h exp=%h",
                 k, dut_vec(), model_vec());
      end
      if (PLL_ARST_N === 1'b0) n_low++;
      if (READY === 1'b1 && rdy < 0) rdy = k;
      if (k == 9) LOCK = 1'b1;
      step();
    end
    checks++;
    if (n_low !== 4) begin
      errors++;
      $display("FAIL nominal_arst_len got=%0d exp=4", n_low);
    end
    checks++;
    if (rdy !== 20) begin
      errors++;
      $display("FAIL nominal_ready_cyc got=%0d exp=20", rdy);
    end
    checks++;
    if ({FABRIC_RESET_N, READY, RETRY_CNT} !== 4'b1100) begin
      errors++;
      $display("FAIL nominal_run got=%b exp=1100",
               {FABRIC_RESET_N, READY, RETRY_CNT});
    end
  endtask

  task automatic test_glitch();
    int s_found;
    int w;
    int r;
    do_reset();
    LOCK = 1'b1;
    s_found = 0;
    for (int k = 0; k < 50; k++) begin
      if (STATE === 3'd2) begin
        s_found = 1;
        break;
      end
      step();
    end
    checks++;
    if (s_found !== 1) begin
      errors++;
      $display("FAIL glitch_reach_stable got=%0d exp=1", s_found);
    end
    w = -1;
    r = -1;
    for (int k = 0; k <= 20; k++) begin
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        $display("FAIL glitch_model k=%0d got=%h exp=%h",
                 k, dut_vec(), model_vec());
      end
      if (STATE === 3'd1 && w < 0) w = k;
      if (READY === 1'b1 && r < 0) r = k;
      if (k == 3) LOCK = 1'b0;
      if (k == 4) LOCK = 1'b1;
      step();
    end
    checks++;
    if (w !== 6) begin
      errors++;
      $display("FAIL glitch_wait_cyc got=%0d exp=6", w);
    end
    checks++;
    if (r !== 15) begin
      errors++;
      $display("FAIL glitch_ready_cyc got=%0d exp=15", r);
    end
    checks++;
    if (RETRY_CNT !== 2'd0) begin
      errors++;
      $display("FAIL glitch_retry got=%0d exp=0", RETRY_CNT);
    end
  endtask

  task automatic test_lock_at_timeout();
    LOCK = 1'b0;
    do_reset();
    for (int k = 0; k <= 23; k++) begin
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        $display("FAIL tmo_edge_model k=%0d got=%h exp=%h",
                 k, dut_vec(), model_vec());
      end
      if (k == 21) LOCK = 1'b1;
      step();
    end
    checks++;
    if ({STATE, RETRY_CNT} !== 5'b010_00) begin
      errors++;
      $display("FAIL tmo_edge_lock_wins got=%b exp=01000",
               {STATE, RETRY_CNT});
    end
  endtask

  task automatic test_timeout_fault();
    int pulses;
    int prev;
    int fc;
    int r;
    logic [1:0] rq[$];
    LOCK = 1'b0;
    do_reset();
    pulses = 0;
    prev = -1;
    fc = -1;
    for (int k = 0; k < 200; k++) begin
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        $display("FAIL fault_model k=%0d got=%h exp=%h",
                 k, dut_vec(), model_vec());
      end
      if (STATE === 3'd0 && prev != 0) begin
        pulses++;
        rq.push_back(RETRY_CNT);
      end
      prev = int'(STATE);
      if (FAULT === 1'b1) begin
        fc = k;
        break;
      end
      step();
    end
    checks++;
    if (pulses !== 3) begin
      errors++;
      $display("FAIL fault_pulses got=%0d exp=3", pulses);
    end
    for (int i = 0; i < rq.size(); i++) begin
      checks++;
      if (rq[i] !== 2'(i)) begin
        errors++;
        $display("FAIL fault_retry_seq i=%0d got=%0d exp=%0d",
                 i, rq[i], i);
      end
    end
    checks++;
    if (fc !== 72) begin
      errors++;
      $display("FAIL fault_cyc got=%0d exp=72", fc);
    end
    repeat (5) step();
    checks++;
    if ({STATE, RETRY_CNT, PLL_ARST_N, FABRIC_RESET_N}
        !== 7'b101_11_00) begin
      errors++;
      $display("FAIL fault_sticky got=%b exp=1011100",
               {STATE, RETRY_CNT, PLL_ARST_N, FABRIC_RESET_N});
    end
    LOCK = 1'b1;
    RETRY_REQ = 1'b1;
    step();
    RETRY_REQ = 1'b0;
    checks++;
    if ({STATE, RETRY_CNT, FAULT} !== 6'b000_00_0) begin
      errors++;
      $display("FAIL fault_retry_req got=%b exp=000000",
               {STATE, RETRY_CNT, FAULT});
    end
    r = -1;
    for (int k = 0; k < 40; k++) begin
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        $display("FAIL refire_model k=%0d got=%h exp=%h",
                 k, dut_vec(), model_vec());
      end
      if (READY === 1'b1) begin
        r = k;
        break;
      end
      step();
    end
    checks++;
    if (r !== 13) begin
      errors++;
      $display("FAIL refire_ready_cyc got=%0d exp=13", r);
    end
  endtask

  task automatic test_lock_loss();
    int fall;
    int lost_n;
    int arst_n;
    checks++;
    if (READY !== 1'b1) begin
      errors++;
      $display("FAIL loss_pre_run got=%b exp=1", READY);
    end
    fall = -1;
    lost_n = 0;
    arst_n = 0;
    for (int k = 0; k <= 12; k++) begin
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        $display("FAIL loss_model k=%0d got=%h exp=%h",
                 k, dut_vec(), model_vec());
      end
      if (FABRIC_RESET_N === 1'b0 && fall < 0) fall = k;
      if (STATE === 3'd4) lost_n++;
      if (PLL_ARST_N === 1'b0) arst_n++;
      if (k == 0) LOCK = 1'b0;
      step();
    end
    checks++;
    if (fall !== 3) begin
      errors++;
      $display("FAIL loss_frn_fall got=%0d exp=3", fall);
    end
    checks++;
    if (lost_n !== 1) begin
      errors++;
      $display("FAIL loss_lost_len got=%0d exp=1", lost_n);
    end
    checks++;
    if (arst_n !== 4) begin
      errors++;
      $display("FAIL loss_arst_len got=%0d exp=4", arst_n);
    end
`ifdef CCC_LOSS_CNT_EN
    checks++;
    if ({LOSS_CNT, LOSS_STICKY} !== 9'b0000_0001_1) begin
      errors++;
      $display("FAIL loss_cnt got=%0d/%b exp=1/1",
               LOSS_CNT, LOSS_STICKY);
    end
`endif
  endtask

  task automatic test_mid_reset();
    int hit;
    do_reset();
    LOCK = 1'b1;
    hit = 0;
    for (int k = 0; k < 50; k++) begin
      if (STATE === 3'd2) begin
        hit = 1;
        break;
      end
      step();
    end
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    checks++;
    if (hit !== 1 || dut_vec() !== 18'd0) begin
      errors++;
      $display("FAIL midrst_stable hit=%0d got=%h exp=0",
               hit, dut_vec());
    end
    LOCK = 1'b0;
    hit = 0;
    for (int k = 0; k < 200; k++) begin
      if (FAULT === 1'b1) begin
        hit = 1;
        break;
      end
      step();
    end
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    checks++;
    if (hit !== 1 || dut_vec() !== 18'd0) begin
      errors++;
      $display("FAIL midrst_fault hit=%0d got=%h exp=0",
               hit, dut_vec());
    end
    LOCK = 1'b1;
    hit = 0;
    for (int k = 0; k < 60; k++) begin
      if (READY === 1'b1) begin
        hit = 1;
        break;
      end
      step();
    end
    RETRY_REQ = 1'b1;
    step();
    RETRY_REQ = 1'b0;
    repeat (3) step();
    checks++;
    if (hit !== 1 || {STATE, READY} !== 4'b011_1) begin
      errors++;
      $display("FAIL run_retry_ignored hit=%0d got=%b exp=0111",
               hit, {STATE, READY});
    end
  endtask

  task automatic test_random();
    int run;
    run = 0;
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      if (run == 0) begin
        LOCK = ($urandom_range(0, 99) < 70);
        run = $urandom_range(1, 40);
      end else begin
        run--;
      end
      RETRY_REQ = ($urandom_range(0, 19) == 0);
      RESET = ($urandom_range(0, 599) == 0);
      step();
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        $display("FAIL random_model k=%0d got=%h exp=%h",
                 k, dut_vec(), model_vec());
      end
    end
    RESET = 1'b0;
    RETRY_REQ = 1'b0;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_glitch();
    test_lock_at_timeout();
    test_timeout_fault();
    test_lock_loss();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
